alu_control: RTL and testbench

- ALU control decoder for the single-cycle/pipelined MIPS-style datapath.
- Maps the 2-bit main-control ALU op class and the instruction funct field (bits 5:0) to the 4-bit ALU operation select.
- Combinational select for same-cycle use, plus a registered copy and an illegal-funct flag for the next pipeline stage.

---
 rtl/alu_control.sv | 78 +++++++
 tb/tb_alu_control.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// rtl/alu_control.sv - ALU control decoder: op class + funct to 4-bit ALU select
// Combinational select and illegal-funct flag, plus registered copies for the next stage.
module alu_control #(
  parameter logic [3:0] RESET_OP = 4'b0010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] alu_op,
  input  logic [5:0] instruction_5_0,
  output logic [3:0] alu_out,
  output logic [3:0] alu_out_q,
  output logic       funct_err,
  output logic       funct_err_sticky
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_SLTU = 4'b1000;
  localparam logic [3:0] SEL_NOR  = 4'b1100;

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;

  logic [3:0] w_sel;
  logic       w_err;
  logic [3:0] r_alu_out_q;
  logic       r_funct_err_sticky;

  always_comb begin
    w_sel = SEL_ADD;
    w_err = 1'b0;
    case (alu_op)
      OP_MEM:    w_sel = SEL_ADD;
      OP_BRANCH: w_sel = SEL_SUB;
      OP_RTYPE: begin
        // Full 6-bit compare so unlisted functs are flagged rather than aliased.
        case (instruction_5_0)
          6'b100000: w_sel = SEL_ADD;
          6'b100001: w_sel = SEL_ADD;
          6'b100010: w_sel = SEL_SUB;
          6'b100011: w_sel = SEL_SUB;
          6'b100100: w_sel = SEL_AND;
          6'b100101: w_sel = SEL_OR;
          6'b100110: w_sel = SEL_XOR;
          6'b100111: w_sel = SEL_NOR;
          6'b101010: w_sel = SEL_SLT;
          6'b101011: w_sel = SEL_SLTU;
          default: begin
            w_sel = SEL_ADD;
            w_err = 1'b1;
          end
        endcase
      end
      default:   w_sel = SEL_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out_q        <= RESET_OP;
      r_funct_err_sticky <= 1'b0;
    end else begin
      r_alu_out_q        <= w_sel;
      r_funct_err_sticky <= r_funct_err_sticky | w_err;
    end
  end

  assign alu_out          = w_sel;
  assign funct_err        = w_err;
  assign alu_out_q        = r_alu_out_q;
  assign funct_err_sticky = r_funct_err_sticky;

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - directed table-driven bench for alu_control
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic [1:0] alu_op;
  logic [5:0] instruction_5_0;
  logic [3:0] alu_out;
  logic [3:0] alu_out_q;
  logic       funct_err;
  logic       funct_err_sticky;

  int n_checks = 0;
  int n_pass   = 0;

  alu_control #(.RESET_OP(4'b0010)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_op           (alu_op),
    .instruction_5_0  (instruction_5_0),
    .alu_out          (alu_out),
    .alu_out_q        (alu_out_q),
    .funct_err        (funct_err),
    .funct_err_sticky (funct_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] exp_sel;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  vec_t vecs[20];
  logic exp_sticky;

  initial begin
    vecs[0]  = '{2'b00, 6'b000000, 4'b0010, 1'b0};
    vecs[1]  = '{2'b00, 6'b101010, 4'b0010, 1'b0};
    vecs[2]  = '{2'b01, 6'b000000, 4'b0110, 1'b0};
    vecs[3]  = '{2'b01, 6'b100101, 4'b0110, 1'b0};
    vecs[4]  = '{2'b11, 6'b000000, 4'b0010, 1'b0};
    vecs[5]  = '{2'b11, 6'b100100, 4'b0010, 1'b0};
    vecs[6]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[7]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[8]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[9]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[10] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[11] = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    vecs[12] = '{2'b10, 6'b100001, 4'b0010, 1'b0};
    vecs[13] = '{2'b10, 6'b100011, 4'b0110, 1'b0};
    vecs[14] = '{2'b10, 6'b100110, 4'b0011, 1'b0};
    vecs[15] = '{2'b10, 6'b101011, 4'b1000, 1'b0};
    vecs[16] = '{2'b10, 6'b000000, 4'b0010, 1'b1};
    vecs[17] = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[18] = '{2'b10, 6'b111111, 4'b0010, 1'b1};
    vecs[19] = '{2'b10, 6'b101000, 4'b0010, 1'b1};

    rst_n = 1'b0;
    alu_op = 2'b00;
    instruction_5_0 = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", {28'd0, alu_out_q}, 32'h2);
    check("reset_sticky", {31'd0, funct_err_sticky}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_sticky = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      alu_op = vecs[i].op;
      instruction_5_0 = vecs[i].funct;
      #1;
      check($sformatf("sel[%0d]", i), {28'd0, alu_out}, {28'd0, vecs[i].exp_sel});
      check($sformatf("err[%0d]", i), {31'd0, funct_err}, {31'd0, vecs[i].exp_err});
      exp_sticky = exp_sticky | vecs[i].exp_err;
      @(posedge clk);
      #1;
      check($sformatf("q[%0d]", i), {28'd0, alu_out_q}, {28'd0, vecs[i].exp_sel});
      check($sformatf("sticky[%0d]", i), {31'd0, funct_err_sticky}, {31'd0, exp_sticky});
    end

    // Async reset between edges, with a set sticky flag to clear.
    @(negedge clk);
    alu_op = 2'b01;
    instruction_5_0 = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    check("branch_q", {28'd0, alu_out_q}, 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q", {28'd0, alu_out_q}, 32'h2);
    check("async_sticky", {31'd0, funct_err_sticky}, 32'h0);
    check("async_comb", {28'd0, alu_out}, 32'h6);

    // Error while in reset: reset wins.
    alu_op = 2'b10;
    instruction_5_0 = 6'b000000;
    @(posedge clk);
    #1;
    check("rst_err_comb", {31'd0, funct_err}, 32'h1);
    check("rst_err_sticky", {31'd0, funct_err_sticky}, 32'h0);
    check("rst_err_q", {28'd0, alu_out_q}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_sticky", {31'd0, funct_err_sticky}, 32'h1);

    // Mid-cycle change: comb follows at once, register waits for the edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    alu_op = 2'b00;
    @(posedge clk);
    #1;
    check("pre_mid_q", {28'd0, alu_out_q}, 32'h2);
    #2;
    alu_op = 2'b10;
    instruction_5_0 = 6'b100101;
    #1;
    check("mid_comb", {28'd0, alu_out}, 32'h1);
    check("mid_hold_q", {28'd0, alu_out_q}, 32'h2);
    @(posedge clk);
    #1;
    check("mid_after_q", {28'd0, alu_out_q}, 32'h1);
    check("mid_sticky", {31'd0, funct_err_sticky}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
